// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between N requesting devices and the arbiter.
// Ports: requests (per-device request), grants (one-hot or zero), busy, grantedIndex.
// The master modport is the arbiter side (drives grants); slave is the device side.
interface round_robin_arbiter_if #(
  parameter int NUMBER_OF_DEVICES = 4
);
  localparam int IW = $clog2(NUMBER_OF_DEVICES);

  logic [NUMBER_OF_DEVICES-1:0] requests;
  logic [NUMBER_OF_DEVICES-1:0] grants;
  logic                         busy;
  logic [IW-1:0]                grantedIndex;

  modport master (
    input  requests,
    output grants,
    output busy,
    output grantedIndex
  );

  modport slave (
    output requests,
    input  grants,
    input  busy,
    input  grantedIndex
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// N-way arbiter, fixed-priority or round-robin, with optional hold-time preemption.
// Latency: request to grant 1 cycle from idle; at least 1 idle cycle between owners.
// Backpressure: none; requests are sampled each edge, owner keeps grant until it drops or is preempted.
// Ports: clock, reset (sync, active-high), bus.master (requests in; grants/busy/grantedIndex out, all registered).
module round_robin_arbiter #(
  parameter int NUMBER_OF_DEVICES = 4,
  parameter int MODE              = 1,
  parameter int MAX_HOLD_CYCLES   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  round_robin_arbiter_if.master bus
);
  localparam int N  = NUMBER_OF_DEVICES;
  localparam int IW = $clog2(N);
  localparam bit HOLD_EN = (MODE == 1) && (MAX_HOLD_CYCLES > 0);
  // Counter keeps one bit when the limit is disabled so the declaration stays legal.
  localparam int HW = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD_CYCLES > 0) ? MAX_HOLD_CYCLES - 1 : 0;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_I);
  localparam logic [IW-1:0] PTR_RESET = IW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0  = N'(1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    grants_q, grants_nxt;
  logic            busy_q, busy_nxt;
  logic [IW-1:0]   index_q, index_nxt;
  logic [IW-1:0]   pointer_q, pointer_nxt;
  logic [HW-1:0]   hold_q, hold_nxt;

  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand_idx;
  int              cand;
  logic            owner_req;
  logic            others_waiting;
  logic            preempt;

  // Winner search. Loops run from the farthest candidate to the nearest so the
  // last assignment made is the highest-priority requester.
  always_comb begin
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    if (MODE == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.requests[i]) winner = IW'(i);
      end
    end else begin
      for (int off = N; off >= 1; off--) begin
        cand = int'(pointer_q) + off;
        if (cand >= N) cand = cand - N;
        cand_idx = IW'(cand);
        if (bus.requests[cand_idx]) winner = cand_idx;
      end
    end
  end

  assign owner_req      = bus.requests[index_q];
  assign others_waiting = |(bus.requests & ~grants_q);
  assign preempt        = HOLD_EN && (hold_q == HOLD_LAST) && owner_req && others_waiting;

  always_comb begin
    state_nxt   = state;
    grants_nxt  = grants_q;
    busy_nxt    = busy_q;
    index_nxt   = index_q;
    pointer_nxt = pointer_q;
    hold_nxt    = hold_q;
    case (state)
      IDLE: begin
        if (|bus.requests) begin
          state_nxt   = GRANTED;
          grants_nxt  = ONE_HOT0 << winner;
          busy_nxt    = 1'b1;
          index_nxt   = winner;
          pointer_nxt = winner;
          hold_nxt    = '0;
        end
      end
      GRANTED: begin
        // Release and preemption both go through IDLE; the pointer already
        // names the owner, so a preempted owner drops to lowest priority.
        if (!owner_req || preempt) begin
          state_nxt  = IDLE;
          grants_nxt = '0;
          busy_nxt   = 1'b0;
          index_nxt  = '0;
        end else if (HOLD_EN && (hold_q != HOLD_LAST)) begin
          hold_nxt = hold_q + HW'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        grants_nxt = '0;
        busy_nxt   = 1'b0;
        index_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      grants_q  <= '0;
      busy_q    <= 1'b0;
      index_q   <= '0;
      pointer_q <= PTR_RESET;
      hold_q    <= '0;
    end else begin
      state     <= state_nxt;
      grants_q  <= grants_nxt;
      busy_q    <= busy_nxt;
      index_q   <= index_nxt;
      pointer_q <= pointer_nxt;
      hold_q    <= hold_nxt;
    end
  end

  assign bus.grants       = grants_q;
  assign bus.busy         = busy_q;
  assign bus.grantedIndex = index_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: three arbiters (round robin unlimited, fixed priority,
// round robin with a 3-cycle hold limit) share clock and reset.
module tb_round_robin_arbiter;
  logic clock;
  logic reset;

  round_robin_arbiter_if #(.NUMBER_OF_DEVICES(4)) if_rr ();
  round_robin_arbiter_if #(.NUMBER_OF_DEVICES(4)) if_fp ();
  round_robin_arbiter_if #(.NUMBER_OF_DEVICES(4)) if_hd ();

  round_robin_arbiter #(.NUMBER_OF_DEVICES(4), .MODE(1), .MAX_HOLD_CYCLES(0)) u_rr (
    .clock(clock), .reset(reset), .bus(if_rr));
  round_robin_arbiter #(.NUMBER_OF_DEVICES(4), .MODE(0), .MAX_HOLD_CYCLES(0)) u_fp (
    .clock(clock), .reset(reset), .bus(if_fp));
  round_robin_arbiter #(.NUMBER_OF_DEVICES(4), .MODE(1), .MAX_HOLD_CYCLES(3)) u_hd (
    .clock(clock), .reset(reset), .bus(if_hd));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    bit         rst;
    int         dut;
    logic [3:0] req;
    logic [3:0] g;
    logic       b;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   failed;

  task automatic add(input string name, input bit rst, input int dut, input logic [3:0] req,
                     input logic [3:0] g, input logic b, input logic [1:0] idx);
    vec_t v;
    v.name = name; v.rst = rst; v.dut = dut; v.req = req; v.g = g; v.b = b; v.idx = idx;
    vecs.push_back(v);
  endtask

  // Apply one cycle of stimulus to the selected arbiter (others see no requests),
  // then sample just after the edge.
  task automatic drive(input bit rst, input int dut, input logic [3:0] req);
    reset = rst;
    if_rr.requests = (dut == 0) ? req : 4'b0000;
    if_fp.requests = (dut == 1) ? req : 4'b0000;
    if_hd.requests = (dut == 2) ? req : 4'b0000;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string name, input int dut, input logic [3:0] eg,
                       input logic eb, input logic [1:0] ei);
    logic [3:0] g;
    logic       b;
    logic [1:0] i;
    case (dut)
      0:       begin g = if_rr.grants; b = if_rr.busy; i = if_rr.grantedIndex; end
      1:       begin g = if_fp.grants; b = if_fp.busy; i = if_fp.grantedIndex; end
      default: begin g = if_hd.grants; b = if_hd.busy; i = if_hd.grantedIndex; end
    endcase
    tests++;
    if (g !== eg || b !== eb || i !== ei) begin
      failed++;
      $display("FAIL %s: got grants=%b busy=%b index=%0d, expected grants=%b busy=%b index=%0d",
               name, g, b, i, eg, eb, ei);
    end
  endtask

  logic [3:0] exp_p [9];

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    if_rr.requests = 4'b0000;
    if_fp.requests = 4'b0000;
    if_hd.requests = 4'b0000;

    // name, rst, dut, requests, grants, busy, index
    add("reset_rr",       1, 0, 4'b0000, 4'b0000, 0, 0);
    add("reset_fp",       1, 1, 4'b0000, 4'b0000, 0, 0);
    add("reset_hd",       1, 2, 4'b0000, 4'b0000, 0, 0);
    add("single",         0, 0, 4'b0100, 4'b0100, 1, 2);
    add("single_drop",    0, 0, 4'b0000, 4'b0000, 0, 0);
    add("idle_stays",     0, 0, 4'b0000, 4'b0000, 0, 0);
    add("rot_reset",      1, 0, 4'b0000, 4'b0000, 0, 0);
    add("rot_g0",         0, 0, 4'b1111, 4'b0001, 1, 0);
    add("rot_idle0",      0, 0, 4'b1110, 4'b0000, 0, 0);
    add("rot_g1",         0, 0, 4'b1111, 4'b0010, 1, 1);
    add("rot_idle1",      0, 0, 4'b1101, 4'b0000, 0, 0);
    add("rot_g2",         0, 0, 4'b1111, 4'b0100, 1, 2);
    add("rot_idle2",      0, 0, 4'b1011, 4'b0000, 0, 0);
    add("rot_g3",         0, 0, 4'b1111, 4'b1000, 1, 3);
    add("rot_idle3",      0, 0, 4'b0111, 4'b0000, 0, 0);
    add("rot_g0_again",   0, 0, 4'b1111, 4'b0001, 1, 0);
    add("hold_others",    0, 0, 4'b1001, 4'b0001, 1, 0);
    add("release_ignore", 0, 0, 4'b1000, 4'b0000, 0, 0);
    add("grant3",         0, 0, 4'b1000, 4'b1000, 1, 3);
    add("release3",       0, 0, 4'b0000, 4'b0000, 0, 0);
    add("wrap",           0, 0, 4'b1001, 4'b0001, 1, 0);
    add("wrap_drop",      0, 0, 4'b0000, 4'b0000, 0, 0);
    add("mid_grant",      0, 0, 4'b0100, 4'b0100, 1, 2);
    add("mid_reset",      1, 0, 4'b0100, 4'b0000, 0, 0);
    add("after_reset",    0, 0, 4'b1111, 4'b0001, 1, 0);
    add("fp_first",       0, 1, 4'b1010, 4'b0010, 1, 1);
    add("fp_release",     0, 1, 4'b1000, 4'b0000, 0, 0);
    add("fp_again",       0, 1, 4'b1010, 4'b0010, 1, 1);
    add("fp_release2",    0, 1, 4'b1000, 4'b0000, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].dut, vecs[k].req);
      check(vecs[k].name, vecs[k].dut, vecs[k].g, vecs[k].b, vecs[k].idx);
    end

    // Fixed priority: device 1 keeps re-winning, device 3 starves.
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 4'b1010);
      check("fp_starve_grant", 1, 4'b0010, 1'b1, 2'd1);
      drive(0, 1, 4'b1000);
      check("fp_starve_release", 1, 4'b0000, 1'b0, 2'd0);
    end

    // Preemption with a 3-cycle limit, devices 0 and 1 both holding requests.
    drive(1, 2, 4'b0000);
    check("hd_reset", 2, 4'b0000, 1'b0, 2'd0);
    exp_p = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
              4'b0010, 4'b0010, 4'b0000, 4'b0001};
    for (int c = 0; c < 9; c++) begin
      drive(0, 2, 4'b0011);
      check($sformatf("hd_preempt_c%0d", c), 2, exp_p[c], |exp_p[c], idx_of(exp_p[c]));
    end

    // A lone owner is never preempted; once its counter has saturated, a new
    // competitor causes preemption at the very next edge.
    drive(1, 2, 4'b0000);
    check("hd_reset2", 2, 4'b0000, 1'b0, 2'd0);
    for (int c = 0; c < 8; c++) begin
      drive(0, 2, 4'b0001);
      check($sformatf("hd_alone_c%0d", c), 2, 4'b0001, 1'b1, 2'd0);
    end
    drive(0, 2, 4'b0011);
    check("hd_sat_preempt", 2, 4'b0000, 1'b0, 2'd0);
    drive(0, 2, 4'b0011);
    check("hd_sat_next", 2, 4'b0010, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
